// File: rtl/alu_exec_seq_if.sv
// alu_exec_seq_if: operation, ALU operand/result and host register-port bundle
// master: requester/ALU/host side; slave: the execute sequencer
interface alu_exec_seq_if #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
);
    logic              start;
    logic [2:0]        opcode;
    logic [SEL_W-1:0]  rx_sel;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] rx_dato;
    logic [DATA_W-1:0] r0_dato;
    logic [2:0]        ry;
    logic [DATA_W-1:0] resul;
    logic [2:0]        flag_in;
    logic [2:0]        flags;
    logic              wr_en;
    logic [SEL_W-1:0]  wr_sel;
    logic [DATA_W-1:0] wr_data;
    logic [SEL_W-1:0]  rd_sel;
    logic [DATA_W-1:0] rd_data;
    modport master (
        output start, opcode, rx_sel, resul, flag_in, wr_en, wr_sel, wr_data, rd_sel,
        input  busy, done, rx_dato, r0_dato, ry, flags, rd_data
    );
    modport slave (
        input  start, opcode, rx_sel, resul, flag_in, wr_en, wr_sel, wr_data, rd_sel,
        output busy, done, rx_dato, r0_dato, ry, flags, rd_data
    );
endinterface

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: register bank plus IDLE/FETCH/EXEC/WB sequencer wrapped around an external ALU
// ports: clk, rst_n (async active-low), bus (alu_exec_seq_if.slave: op request, ALU operands/result, host read/write)
module alu_exec_seq #(
    parameter int DATA_W = 8,
    parameter int SEL_W  = 3
) (
    input logic          clk,
    input logic          rst_n,
    alu_exec_seq_if.slave bus
);
    localparam int NREG = 2 ** SEL_W;
    typedef enum logic [1:0] {IDLE, FETCH, EXEC, WB} state_t;
    state_t            state_q, state_d;
    logic [DATA_W-1:0] regs_q [NREG];
    logic [DATA_W-1:0] regs_d [NREG];
    logic [2:0]        op_q, op_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [2:0]        flg_q, flg_d;
    logic [DATA_W-1:0] rx_q, rx_d;
    logic [DATA_W-1:0] r0_q, r0_d;
    logic [2:0]        ry_q, ry_d;
    logic [2:0]        flags_q, flags_d;
    logic              done_q, done_d;
    always_comb begin
        state_d = state_q;
        regs_d  = regs_q;
        op_d    = op_q;
        sel_d   = sel_q;
        res_d   = res_q;
        flg_d   = flg_q;
        rx_d    = rx_q;
        r0_d    = r0_q;
        ry_d    = ry_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                // host writes only land while idle, so the bank is frozen under an operation
                if (bus.wr_en) regs_d[bus.wr_sel] = bus.wr_data;
                if (bus.start) begin
                    op_d    = bus.opcode;
                    sel_d   = bus.rx_sel;
                    state_d = FETCH;
                end
            end
            FETCH: begin
                rx_d    = regs_q[sel_q];
                r0_d    = regs_q[0];
                ry_d    = op_q;
                state_d = EXEC;
            end
            EXEC: begin
                res_d   = bus.resul;
                flg_d   = bus.flag_in;
                state_d = WB;
            end
            default: begin
                regs_d[0] = res_q;
                flags_d   = flg_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            regs_q  <= '{default: '0};
            op_q    <= '0;
            sel_q   <= '0;
            res_q   <= '0;
            flg_q   <= '0;
            rx_q    <= '0;
            r0_q    <= '0;
            ry_q    <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            regs_q  <= regs_d;
            op_q    <= op_d;
            sel_q   <= sel_d;
            res_q   <= res_d;
            flg_q   <= flg_d;
            rx_q    <= rx_d;
            r0_q    <= r0_d;
            ry_q    <= ry_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end
    assign bus.busy    = state_q != IDLE;
    assign bus.done    = done_q;
    assign bus.rx_dato = rx_q;
    assign bus.r0_dato = r0_q;
    assign bus.ry      = ry_q;
    assign bus.flags   = flags_q;
    assign bus.rd_data = regs_q[bus.rd_sel];
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb_alu_exec_seq: directed self-checking bench for alu_exec_seq with a small external ALU
module tb_alu_exec_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;
    logic [8:0] full;
    alu_exec_seq_if #(.DATA_W(8), .SEL_W(3)) bus ();
    alu_exec_seq #(.DATA_W(8), .SEL_W(3)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    // ALU: 000 add, 001 sub, 101 and, 110 or, 111 xor; zero flag looks at the carry bit too
    always_comb begin
        case (bus.ry)
            3'b000:  full = {1'b0, bus.r0_dato} + {1'b0, bus.rx_dato};
            3'b001:  full = {1'b0, bus.r0_dato} - {1'b0, bus.rx_dato};
            3'b101:  full = {1'b0, bus.r0_dato & bus.rx_dato};
            3'b110:  full = {1'b0, bus.r0_dato | bus.rx_dato};
            3'b111:  full = {1'b0, bus.r0_dato ^ bus.rx_dato};
            default: full = {1'b0, bus.r0_dato};
        endcase
        bus.resul   = full[7:0];
        bus.flag_in = {full == 9'd0, full[8], full[7]};
    end
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wr(input logic [2:0] s, input logic [7:0] d);
        bus.wr_en = 1'b1; bus.wr_sel = s; bus.wr_data = d;
        tick();
        bus.wr_en = 1'b0;
    endtask
    task automatic go(input logic [2:0] op, input logic [2:0] s);
        bus.start = 1'b1; bus.opcode = op; bus.rx_sel = s;
        tick();
        bus.start = 1'b0;
    endtask
    task automatic wait_done(output int n);
        n = 0;
        while (bus.done !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
    endtask
    task automatic test_reset();
        rst_n = 1'b0;
        #22;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL rst_done got=%0b exp=0", bus.done); end
        checks++; if (bus.flags !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", bus.flags); end
        checks++; if ({bus.rx_dato, bus.r0_dato, bus.ry} !== 19'd0) begin failures++; $display("FAIL rst_operands got=%h exp=0", {bus.rx_dato, bus.r0_dato, bus.ry}); end
        rst_n = 1'b1;
        tick();
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL rst_idle_busy got=%0b exp=0", bus.busy); end
        bus.rd_sel = 3'd5; #1;
        checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL rst_r5 got=%h exp=00", bus.rd_data); end
    endtask
    task automatic test_add();
        int n;
        wr(3'd0, 8'h05); wr(3'd1, 8'h03);
        go(3'b000, 3'd1);
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL add_busy got=%0b exp=1", bus.busy); end
        tick();
        checks++; if (bus.ry !== 3'b000) begin failures++; $display("FAIL add_ry got=%b exp=000", bus.ry); end
        checks++; if (bus.r0_dato !== 8'h05) begin failures++; $display("FAIL add_r0_dato got=%h exp=05", bus.r0_dato); end
        checks++; if (bus.rx_dato !== 8'h03) begin failures++; $display("FAIL add_rx_dato got=%h exp=03", bus.rx_dato); end
        wait_done(n);
        checks++; if (n != 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", n); end
        bus.rd_sel = 3'd0; #1;
        checks++; if (bus.rd_data !== 8'h08) begin failures++; $display("FAIL add_r0 got=%h exp=08", bus.rd_data); end
        checks++; if (bus.flags !== 3'b000) begin failures++; $display("FAIL add_flags got=%b exp=000", bus.flags); end
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL add_busy_in_done got=%0b exp=0", bus.busy); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL add_done_width got=%0b exp=0", bus.done); end
    endtask
    task automatic test_sub_borrow();
        int n;
        wr(3'd0, 8'h05); wr(3'd1, 8'h07);
        go(3'b001, 3'd1);
        wait_done(n);
        checks++; if (n != 3) begin failures++; $display("FAIL sub_latency got=%0d exp=3", n); end
        bus.rd_sel = 3'd0; #1;
        checks++; if (bus.rd_data !== 8'hFE) begin failures++; $display("FAIL sub_r0 got=%h exp=fe", bus.rd_data); end
        checks++; if (bus.flags !== 3'b011) begin failures++; $display("FAIL sub_flags got=%b exp=011", bus.flags); end
        tick();
    endtask
    task automatic test_add_wrap();
        int n;
        wr(3'd0, 8'hFF); wr(3'd3, 8'h01);
        go(3'b000, 3'd3);
        wait_done(n);
        bus.rd_sel = 3'd0; #1;
        checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL wrap_r0 got=%h exp=00", bus.rd_data); end
        checks++; if (bus.flags !== 3'b010) begin failures++; $display("FAIL wrap_flags got=%b exp=010", bus.flags); end
        tick();
    endtask
    task automatic test_xor_self();
        int n;
        wr(3'd0, 8'h5A);
        go(3'b111, 3'd0);
        wait_done(n);
        bus.rd_sel = 3'd0; #1;
        checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL xor_r0 got=%h exp=00", bus.rd_data); end
        checks++; if (bus.flags !== 3'b100) begin failures++; $display("FAIL xor_flags got=%b exp=100", bus.flags); end
        tick();
        checks++; if (bus.rx_dato !== 8'h5A || bus.r0_dato !== 8'h5A || bus.ry !== 3'b111) begin failures++; $display("FAIL xor_hold got=%h/%h/%b exp=5a/5a/111", bus.rx_dato, bus.r0_dato, bus.ry); end
    endtask
    task automatic test_busy_rules();
        int n;
        int cnt;
        wr(3'd0, 8'h10); wr(3'd1, 8'h20);
        go(3'b000, 3'd1);
        bus.start = 1'b1; bus.opcode = 3'b101;
        bus.wr_en = 1'b1; bus.wr_sel = 3'd1; bus.wr_data = 8'hAA;
        tick();
        bus.start = 1'b0; bus.wr_en = 1'b0;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done === 1'b1) cnt++;
            tick();
        end
        checks++; if (cnt != 1) begin failures++; $display("FAIL busy_done_count got=%0d exp=1", cnt); end
        bus.rd_sel = 3'd1; #1;
        checks++; if (bus.rd_data !== 8'h20) begin failures++; $display("FAIL busy_r1 got=%h exp=20", bus.rd_data); end
        bus.rd_sel = 3'd0; #1;
        checks++; if (bus.rd_data !== 8'h30) begin failures++; $display("FAIL busy_r0 got=%h exp=30", bus.rd_data); end
        wr(3'd0, 8'h3C);
        bus.wr_en = 1'b1; bus.wr_sel = 3'd1; bus.wr_data = 8'h0F;
        bus.start = 1'b1; bus.opcode = 3'b101; bus.rx_sel = 3'd1;
        tick();
        bus.wr_en = 1'b0; bus.start = 1'b0;
        wait_done(n);
        checks++; if (n != 3) begin failures++; $display("FAIL wrstart_latency got=%0d exp=3", n); end
        bus.rd_sel = 3'd0; #1;
        checks++; if (bus.rd_data !== 8'h0C) begin failures++; $display("FAIL wrstart_r0 got=%h exp=0c", bus.rd_data); end
        bus.rd_sel = 3'd1; #1;
        checks++; if (bus.rd_data !== 8'h0F) begin failures++; $display("FAIL wrstart_r1 got=%h exp=0f", bus.rd_data); end
        checks++; if (bus.flags !== 3'b000) begin failures++; $display("FAIL wrstart_flags got=%b exp=000", bus.flags); end
        tick();
    endtask
    task automatic test_back_to_back();
        int n;
        wr(3'd0, 8'h80); wr(3'd1, 8'h80);
        go(3'b000, 3'd1);
        wait_done(n);
        checks++; if (bus.flags !== 3'b010) begin failures++; $display("FAIL b2b_first_flags got=%b exp=010", bus.flags); end
        bus.start = 1'b1; bus.opcode = 3'b001; bus.rx_sel = 3'd1;
        tick();
        bus.start = 1'b0;
        checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin failures++; $display("FAIL b2b_accept got=busy%0b/done%0b exp=busy1/done0", bus.busy, bus.done); end
        wait_done(n);
        checks++; if (n != 3) begin failures++; $display("FAIL b2b_latency got=%0d exp=3", n); end
        bus.rd_sel = 3'd0; #1;
        checks++; if (bus.rd_data !== 8'h80) begin failures++; $display("FAIL b2b_r0 got=%h exp=80", bus.rd_data); end
        checks++; if (bus.flags !== 3'b011) begin failures++; $display("FAIL b2b_flags got=%b exp=011", bus.flags); end
        tick();
        checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL b2b_done_width got=%0b exp=0", bus.done); end
    endtask
    task automatic test_reset_midop();
        int cnt;
        wr(3'd0, 8'h11); wr(3'd2, 8'h22);
        go(3'b000, 3'd2);
        tick();
        checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%0b exp=1", bus.busy); end
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", bus.busy); end
        checks++; if (bus.flags !== 3'b000) begin failures++; $display("FAIL midrst_flags got=%b exp=000", bus.flags); end
        checks++; if (bus.r0_dato !== 8'h00 || bus.rx_dato !== 8'h00) begin failures++; $display("FAIL midrst_operands got=%h/%h exp=00/00", bus.r0_dato, bus.rx_dato); end
        for (int i = 0; i < 8; i++) begin
            bus.rd_sel = 3'(i); #1;
            checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL midrst_r%0d got=%h exp=00", i, bus.rd_data); end
        end
        tick();
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus.done === 1'b1) cnt++;
        end
        checks++; if (cnt != 0) begin failures++; $display("FAIL midrst_done_count got=%0d exp=0", cnt); end
        bus.rd_sel = 3'd0; #1;
        checks++; if (bus.rd_data !== 8'h00) begin failures++; $display("FAIL midrst_r0_after got=%h exp=00", bus.rd_data); end
    endtask
    initial begin
        bus.start = 1'b0; bus.opcode = '0; bus.rx_sel = '0;
        bus.wr_en = 1'b0; bus.wr_sel = '0; bus.wr_data = '0; bus.rd_sel = '0;
        test_reset();
        test_add();
        test_sub_borrow();
        test_add_wrap();
        test_xor_self();
        test_busy_rules();
        test_back_to_back();
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
